// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART controller: register map, bit positions,
// TX sequencer state encoding and the STATUS byte packer.
package uart_ctrl_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int ST_TX_SPACE = 0;
    localparam int ST_RX_AVAIL = 1;
    localparam int ST_TX_IDLE  = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_TX_OVF   = 4;

    // CTRL bit positions
    localparam int CT_RX_IE = 0;
    localparam int CT_TX_IE = 1;
    localparam int CT_FLUSH = 7;

    // Transmitter handshake sequencer
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_START   = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_e;

    // Assemble the STATUS byte; unused upper bits read as zero
    function automatic logic [7:0] pack_status(input logic tx_space,
                                               input logic rx_avail,
                                               input logic tx_idle,
                                               input logic rx_ovf,
                                               input logic tx_ovf);
        logic [7:0] s;
        s              = 8'h00;
        s[ST_TX_SPACE] = tx_space;
        s[ST_RX_AVAIL] = rx_avail;
        s[ST_TX_IDLE]  = tx_idle;
        s[ST_RX_OVF]   = rx_ovf;
        s[ST_TX_OVF]   = tx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// CPU bus plus transmitter/receiver handshake bundle for uart_ctrl.
// slave = the controller, master = the CPU/PHY side driving it.
interface uart_ctrl_if;
    logic       ce;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_ready;
    logic [7:0] rx_data;

    modport slave (
        input  ce, we, addr, wdata, tx_busy, rx_ready, rx_data,
        output rdata, irq, tx_start, tx_data
    );

    modport master (
        output ce, we, addr, wdata, tx_busy, rx_ready, rx_data,
        input  rdata, irq, tx_start, tx_data
    );
endinterface

// File: rtl/uart_ctrl_fifo.sv
// Synchronous FIFO with a combinational head. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a pop frees the head slot on the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer update; flush overrides any concurrent push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    // Storage write; no reset needed, pointers define validity
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX/RX FIFOs, DATA/STATUS/CTRL registers,
// transmitter start/busy sequencer and a level interrupt.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus
);
    logic       rd_en, wr_en, flush;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       tx_idle;
    logic       tx_drop, rx_drop, stat_rd;

    logic [7:0] rdata_d, rdata_q;
    logic       irq_d, irq_q;
    logic       rx_ie_q, tx_ie_q;
    logic       rx_ovf_q, tx_ovf_q;
    tx_state_e  state_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;

    assign rd_en   = bus.ce & ~bus.we;
    assign wr_en   = bus.ce &  bus.we;
    assign stat_rd = rd_en & (bus.addr == ADDR_STATUS);
    assign flush   = wr_en & (bus.addr == ADDR_CTRL) & bus.wdata[CT_FLUSH];

    // TX side: CPU pushes, sequencer pops when launching a byte
    assign tx_push = wr_en & (bus.addr == ADDR_DATA);
    assign tx_pop  = (state_q == TX_IDLE) & ~tx_empty & ~bus.tx_busy & ~flush;
    assign tx_drop = tx_push & tx_full & ~tx_pop;
    assign tx_idle = tx_empty & (state_q == TX_IDLE);

    // RX side: receiver pushes, CPU DATA read pops
    assign rx_push = bus.rx_ready;
    assign rx_pop  = rd_en & (bus.addr == ADDR_DATA) & ~rx_empty;
    assign rx_drop = rx_push & rx_full & ~rx_pop & ~flush;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .flush_i (flush),
        .din_i   (bus.wdata),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .flush_i (flush),
        .din_i   (bus.rx_data),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Read data mux for the addressed register
    always_comb begin
        rdata_d = 8'h00;
        unique case (bus.addr)
            ADDR_DATA:   rdata_d = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: rdata_d = pack_status(~tx_full, ~rx_empty, tx_idle,
                                               rx_ovf_q, tx_ovf_q);
            ADDR_CTRL: begin
                rdata_d[CT_RX_IE] = rx_ie_q;
                rdata_d[CT_TX_IE] = tx_ie_q;
            end
            default:     rdata_d = 8'h00;
        endcase
    end

    assign irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle);

    // Register file: read data, CTRL, sticky overflow flags, interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= 8'h00;
            rx_ie_q  <= 1'b0;
            tx_ie_q  <= 1'b0;
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (rd_en) rdata_q <= rdata_d;
            if (wr_en && bus.addr == ADDR_CTRL) begin
                rx_ie_q <= bus.wdata[CT_RX_IE];
                tx_ie_q <= bus.wdata[CT_TX_IE];
            end
            // A new overflow on the clearing read still latches, so no event is lost
            rx_ovf_q <= rx_drop | (rx_ovf_q & ~stat_rd);
            tx_ovf_q <= tx_drop | (tx_ovf_q & ~stat_rd);
            irq_q    <= irq_d;
        end
    end

    // Transmitter sequencer with registered start pulse and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_data_q  <= tx_head;
                        tx_start_q <= 1'b1;
                        state_q    <= TX_START;
                    end
                end
                TX_START:   state_q <= TX_WAIT_HI;
                TX_WAIT_HI: if (bus.tx_busy)  state_q <= TX_WAIT_LO;
                TX_WAIT_LO: if (!bus.tx_busy) state_q <= TX_IDLE;
                default:    state_q <= TX_IDLE;
            endcase
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.irq      = irq_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a simple transmitter model that holds
// tx_busy for 20 cycles after each start pulse.
module tb_uart_ctrl;
    logic clk;
    logic rst;
    uart_ctrl_if bus();

    uart_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] sent_q[$];
    int         bcnt = 0;
    logic       hold = 1'b0;
    logic [7:0] d;
    int         base;

    // Transmitter model: logs launched bytes, busy for 20 cycles per byte
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            sent_q.push_back(bus.tx_data);
            bcnt = 20;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
        end
        bus.tx_busy = hold || (bcnt > 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = v;
        @(negedge clk);
        bus.ce = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.ce = 1'b0;
        v = bus.rdata;
    endtask

    task automatic rx_byte(input logic [7:0] v);
        @(negedge clk);
        bus.rx_ready = 1'b1; bus.rx_data = v;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    // Wait until n bytes have been launched and the transmitter is quiet
    task automatic wait_tx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while ((sent_q.size() < n || bus.tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (k < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
        bus.rx_ready = 1'b0; bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rdata",    bus.rdata,    8'h00);
        chk("rst_irq",      bus.irq,      1'b0);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_data",  bus.tx_data,  8'h00);
        rst = 1'b0;

        // Idle status, no spurious start
        bus_rd(2'd1, d);
        chk("status_reset", d, 8'h05);
        repeat (5) @(negedge clk);
        chk("no_start_idle", sent_q.size(), 0);
        chk("irq_idle", bus.irq, 1'b0);

        // Two bytes out, first start two edges after the write edge
        bus_wr(2'd0, 8'h41);
        chk("start_lat_pre", bus.tx_start, 1'b0);
        @(negedge clk);
        chk("start_lat", bus.tx_start, 1'b1);
        bus_wr(2'd0, 8'h42);
        wait_tx("tx2_timeout", 2, 300);
        chk("tx2_count", sent_q.size(), 2);
        chk("tx2_byte0", sent_q[0], 8'h41);
        chk("tx2_byte1", sent_q[1], 8'h42);
        bus_rd(2'd1, d);
        chk("tx2_idle_status", d, 8'h05);

        // TX overflow while the transmitter is held busy
        hold = 1'b1;
        repeat (2) @(negedge clk);
        base = sent_q.size();
        for (int i = 0; i < 17; i++) bus_wr(2'd0, 8'h60 + 8'(i));
        bus_rd(2'd1, d);
        chk("tx_ovf_status", d, 8'h10);
        bus_rd(2'd1, d);
        chk("tx_ovf_cleared", d, 8'h00);
        chk("tx_held_no_start", sent_q.size(), base);
        hold = 1'b0;
        wait_tx("tx16_timeout", base + 16, 1500);
        chk("tx16_count", sent_q.size(), base + 16);
        chk("tx16_first", sent_q[base], 8'h60);
        chk("tx16_last",  sent_q[base + 15], 8'h6F);

        // RX path and interrupt
        rx_byte(8'h55);
        rx_byte(8'hAA);
        bus_wr(2'd2, 8'h01);
        @(negedge clk);
        chk("irq_rx_set", bus.irq, 1'b1);
        bus_rd(2'd2, d);
        chk("ctrl_readback", d, 8'h01);
        bus_rd(2'd0, d);
        chk("rx_read0", d, 8'h55);
        bus_rd(2'd0, d);
        chk("rx_read1", d, 8'hAA);
        @(negedge clk);
        chk("irq_rx_clear", bus.irq, 1'b0);
        bus_rd(2'd0, d);
        chk("rx_read_empty", d, 8'h00);

        // RX overflow, contents kept in order
        for (int i = 0; i < 17; i++) rx_byte(8'h10 + 8'(i));
        bus_rd(2'd1, d);
        chk("rx_ovf_status", d, 8'h0F);
        for (int i = 0; i < 16; i++) begin
            bus_rd(2'd0, d);
            chk("rx_fifo_order", d, 8'h10 + 8'(i));
        end
        bus_rd(2'd0, d);
        chk("rx_drained", d, 8'h00);
        bus_rd(2'd1, d);
        chk("rx_ovf_cleared", d, 8'h05);

        // Reset during WAIT_LO with three bytes still queued
        base = sent_q.size();
        for (int i = 0; i < 4; i++) bus_wr(2'd0, 8'h71 + 8'(i));
        begin
            int k;
            k = 0;
            while (sent_q.size() <= base && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_launch_timeout", (k < 50), 1);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx_start", bus.tx_start, 1'b0);
        chk("rst_mid_tx_data",  bus.tx_data,  8'h00);
        rst = 1'b0;
        bus_rd(2'd1, d);
        chk("rst_mid_status", d, 8'h05);
        repeat (60) @(negedge clk);
        chk("rst_mid_no_resend", sent_q.size(), base + 1);
        chk("rst_mid_byte", sent_q[base], 8'h71);

        // TX-idle interrupt, then flush of a queued RX byte
        bus_wr(2'd2, 8'h02);
        @(negedge clk);
        chk("irq_tx_idle", bus.irq, 1'b1);
        rx_byte(8'h99);
        bus_wr(2'd2, 8'h80);
        bus_rd(2'd1, d);
        chk("flush_status", d, 8'h05);
        bus_rd(2'd2, d);
        chk("flush_ctrl", d, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller sitting between the CPU data bus and the async transmitter/receiver pair. It buffers outbound bytes in a TX FIFO and sequences the transmitter's start/busy handshake. It captures inbound bytes from the receiver into an RX FIFO and exposes data, status and control registers to software. It also raises an interrupt line to the CPU when receive data is pending.

## Interface
- FIFO_DEPTH, 16: entries per FIFO; power of 2, minimum 2.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- ce  input  1  bus access strobe; one access per cycle when high.
- we  input  1  1 = write, 0 = read; sampled when ce=1.
- addr  input  2  word select: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- wdata  input  8  write data.
- rdata  output  8  read data, registered.
- irq  output  1  interrupt request, level.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to transmit, stable while tx_start=1.
- tx_busy  input  1  transmitter busy.
- rx_ready  input  1  one-cycle "byte received" strobe from the receiver.
- rx_data  input  8  received byte, valid when rx_ready=1.

## Operation
- DATA write: pushes wdata into the TX FIFO. If the TX FIFO is full, the byte is dropped and sticky tx_ovf is set.
- DATA read: returns the RX FIFO head and pops it. If the RX FIFO is empty, it returns 0x00 and no pop occurs.
- STATUS read returns these bits; the read clears rx_ovf and tx_ovf:
  - bit0 tx_space: TX FIFO not full.
  - bit1 rx_avail: RX FIFO not empty.
  - bit2 tx_idle: TX FIFO empty and FSM in IDLE.
  - bit3 rx_ovf.
  - bit4 tx_ovf.
  - bits 7:5 are 0.
- STATUS writes are ignored.
- CTRL register: bit0 rx_ie, bit1 tx_ie; read back as written, other bits 0. A CTRL write with bit7=1 flushes both FIFOs (pointers to 0) and is otherwise treated as a normal write.
- Reserved address: reads 0x00, writes ignored.
- irq = (rx_ie & rx_avail) | (tx_ie & tx_idle).
- RX capture: on rx_ready, push rx_data. If the RX FIFO is full, the byte is dropped and rx_ovf is set. The existing contents are kept.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty and tx_busy=0, register the head into tx_data, pop it, go to START.
  - START: tx_start=1 for exactly this cycle, go to WAIT_HI.
  - WAIT_HI: when tx_busy=1, go to WAIT_LO.
  - WAIT_LO: when tx_busy=0, go to IDLE.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle both take effect; count is unchanged. This holds even when the FIFO is full (pop frees the slot) or empty (push-only takes effect, pop ignored).
  - rx_ready coincident with a DATA read: both are honoured.
  - Flush coincident with a push or pop: flush wins.
- Reset mid-transfer: the FSM returns to IDLE and any byte already handed to the transmitter completes on its own. No re-send occurs.

## Timing
- Reset values:
  - rdata=0, irq=0, tx_start=0, tx_data=0.
  - FIFOs empty, flags 0, CTRL=0, FSM=IDLE.
- Read latency: 1 cycle. rdata is updated on the clock edge following ce&~we and holds until the next read. The pop and flag-clear take effect on that same edge.
- Write takes effect on the edge where ce&we. A TX push is visible to the FSM the next cycle.
- First tx_start is asserted 2 cycles after the DATA write edge (push edge, then IDLE→START edge). Thereafter it is asserted one cycle after the START state is entered.
- Byte-to-byte: after tx_busy falls, the next tx_start comes 2 cycles later if the FIFO is non-empty.
- An RX byte is visible in STATUS.rx_avail one cycle after rx_ready.
- irq is registered: 1-cycle lag from the condition.

## Structure
- Shared package constants:
  - Register addresses: DATA=0, STATUS=1, CTRL=2.
  - STATUS and CTRL bit indices.
  - TX FSM state encoding: IDLE, START, WAIT_HI, WAIT_LO (2 bits).
- Sub-module uart_fifo:
  - Parameterised synchronous FIFO (DEPTH, WIDTH=8), instantiated twice.
  - Ports: push, pop, flush, din, dout (head, combinational), full, empty.
  - Uses $clog2(DEPTH)+1-bit read/write pointers; the MSB is the wrap bit distinguishing full from empty.

## Test plan
- Reset then STATUS read → 0x05 (tx_space=1, tx_idle=1); irq=0; tx_start never pulses.
- Write DATA 0x41, 0x42; model tx_busy high for 20 cycles after each start → tx_start pulses twice with tx_data 0x41 then 0x42; STATUS.tx_idle returns to 1.
- Hold tx_busy=1 and write 17 bytes with FIFO_DEPTH=16 → 16 bytes are queued (the first is popped into START once busy drops), the 17th is dropped, STATUS bit4=1, and a second STATUS read shows bit4=0.
- rx_ready with 0x55 then 0xAA, CTRL=0x01 → irq=1; DATA reads return 0x55 then 0xAA; irq=0 after the second pop; a third read returns 0x00.
- Apply 17 rx_ready strobes without reads → rx_ovf=1; the first 16 bytes are read back in order.
- Assert rst during WAIT_LO with 3 bytes queued → FIFOs empty, FSM IDLE, no further tx_start after the transmitter finishes.
